execute_stage_md: RTL and testbench

Pipelined execute stage for the RV64 core. It is the successor to the single-cycle combinational execute wrapper. Single-cycle ALU operations still go through the existing `arithmeticLogicUnit` instance. The stage adds valid/ready handshakes on both sides, a registered output slot, and an iterative multi-cycle multiply/divide unit for the RV M-extension. It sits between decode and the memory stage, and it back-pressures decode while a mul/div operation is in flight.

---
 rtl/execute_stage_md.sv | 232 +++++++++++++++++++++++
 tb/tb_execute_stage_md.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_md.sv
// execute_stage_md: pipelined RV64 execute stage.
// ALU operations complete in one cycle into a registered output slot that uses
// valid/ready handshakes on both sides. With EXEC_STAGE_MULDIV_EN defined, an
// iterative shift-add multiplier / restoring divider handles the M extension
// with a fixed latency of XLEN+1 cycles. Without the macro, mul/div requests
// complete in one cycle with out_data=0 and out_illegal=1.

module arithmeticLogicUnit #(
    parameter int XLEN       = 64,
    parameter int SEL_SIZE   = 4,
    parameter int SHIFT_SIZE = 6
) (
    input  logic                  enable,
    input  logic [SEL_SIZE-1:0]   sel,
    input  logic [SHIFT_SIZE-1:0] shift_amt,
    input  logic [XLEN-1:0]       a,
    input  logic [XLEN-1:0]       b,
    output logic [XLEN-1:0]       result
);
    // Combinational ALU; a disabled ALU yields zero.
    always_comb begin
        result = '0;
        if (enable) begin
            case (sel)
                SEL_SIZE'(0): result = a + b;
                SEL_SIZE'(1): result = a - b;
                SEL_SIZE'(2): result = a & b;
                SEL_SIZE'(3): result = a | b;
                SEL_SIZE'(4): result = a ^ b;
                SEL_SIZE'(5): result = a << shift_amt;
                SEL_SIZE'(6): result = a >> shift_amt;
                SEL_SIZE'(7): result = $signed(a) >>> shift_amt;
                SEL_SIZE'(8): result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                SEL_SIZE'(9): result = {{(XLEN-1){1'b0}}, (a < b)};
                default:      result = '0;
            endcase
        end
    end
endmodule

module execute_stage_md #(
    parameter int XLEN       = 64,
    parameter int SEL_SIZE   = 4,
    parameter int SHIFT_SIZE = 6,
    parameter int RD_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_md,
    input  logic [2:0]            in_md_op,
    input  logic                  in_alu_enable,
    input  logic [SEL_SIZE-1:0]   in_alu_sel,
    input  logic [SHIFT_SIZE-1:0] in_shift_amt,
    input  logic [XLEN-1:0]       in_a,
    input  logic [XLEN-1:0]       in_b,
    input  logic [RD_W-1:0]       in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic [RD_W-1:0]       out_rd,
    output logic                  out_illegal,
    output logic                  busy
);
    logic [XLEN-1:0] alu_result;
    logic            slot_free;
    logic            accept;

    arithmeticLogicUnit #(
        .XLEN(XLEN), .SEL_SIZE(SEL_SIZE), .SHIFT_SIZE(SHIFT_SIZE)
    ) u_alu (
        .enable(in_alu_enable), .sel(in_alu_sel), .shift_amt(in_shift_amt),
        .a(in_a), .b(in_b), .result(alu_result)
    );

    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

`ifdef EXEC_STAGE_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state_reg, state_next;

    logic [CNT_W-1:0] count_reg;
    logic [XLEN-1:0]  acc_hi_reg, acc_lo_reg, opnd_reg;
    logic [2:0]       op_reg;
    logic [RD_W-1:0]  rd_reg;
    logic             neg_q_reg, neg_r_reg, b_zero_reg;

    logic             a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic [XLEN:0]    mul_sum, div_r, div_diff;
    logic [XLEN-1:0]  iter_hi, iter_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]  quot_fix, rem_fix, md_result;

    assign in_ready = !rst && (state_reg == IDLE) && slot_free;
    assign busy     = (state_reg != IDLE);

    // Operand signedness and magnitudes at accept time.
    always_comb begin
        a_signed = (in_md_op == 3'b001) || (in_md_op == 3'b010) ||
                   (in_md_op == 3'b100) || (in_md_op == 3'b110);
        b_signed = (in_md_op == 3'b001) || (in_md_op == 3'b100) || (in_md_op == 3'b110);
        a_neg    = a_signed && in_a[XLEN-1];
        b_neg    = b_signed && in_b[XLEN-1];
        a_mag    = a_neg ? -in_a : in_a;
        b_mag    = b_neg ? -in_b : in_b;
    end

    // One shift-add (multiply) or restoring-subtract (divide) step.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_reg} + {1'b0, (acc_lo_reg[0] ? opnd_reg : '0)};
        div_r    = {acc_hi_reg, acc_lo_reg[XLEN-1]};
        div_diff = div_r - {1'b0, opnd_reg};
        if (op_reg[2]) begin
            if (!div_diff[XLEN]) begin
                iter_hi = div_diff[XLEN-1:0];
                iter_lo = {acc_lo_reg[XLEN-2:0], 1'b1};
            end else begin
                iter_hi = div_r[XLEN-1:0];
                iter_lo = {acc_lo_reg[XLEN-2:0], 1'b0};
            end
        end else begin
            iter_hi = mul_sum[XLEN:1];
            iter_lo = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
        end
    end

    // Sign fix-up and divide-by-zero handling applied in FINISH.
    always_comb begin
        prod_fix = neg_q_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
        quot_fix = b_zero_reg ? '1 : (neg_q_reg ? -acc_lo_reg : acc_lo_reg);
        rem_fix  = neg_r_reg ? -acc_hi_reg : acc_hi_reg;
        case (op_reg)
            3'b000:                 md_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: md_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         md_result = quot_fix;
            default:                md_result = rem_fix;
        endcase
    end

    // Mul/div state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state: XLEN iterations in RUN, then wait in FINISH for a free slot.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && in_is_md) state_next = RUN;
            RUN:     if (count_reg == CNT_W'(XLEN-1)) state_next = FINISH;
            FINISH:  if (slot_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Mul/div datapath: latch operands on accept, iterate while in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opnd_reg   <= '0;
            op_reg     <= '0;
            rd_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            b_zero_reg <= 1'b0;
        end else if (state_reg == IDLE && accept && in_is_md) begin
            count_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= in_md_op[2] ? a_mag : b_mag;
            opnd_reg   <= in_md_op[2] ? b_mag : a_mag;
            op_reg     <= in_md_op;
            rd_reg     <= in_rd;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            b_zero_reg <= (in_b == '0);
        end else if (state_reg == RUN) begin
            count_reg  <= count_reg + 1'b1;
            acc_hi_reg <= iter_hi;
            acc_lo_reg <= iter_lo;
        end
    end
`else
    logic [2:0] unused_md_op;

    assign unused_md_op = in_md_op;
    assign in_ready     = !rst && slot_free;
    assign busy         = 1'b0;
`endif

    // Output slot: load on ALU accept or mul/div completion, clear on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (accept) begin
`ifdef EXEC_STAGE_MULDIV_EN
            if (!in_is_md) begin
                out_valid   <= 1'b1;
                out_data    <= alu_result;
                out_rd      <= in_rd;
                out_illegal <= 1'b0;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
`else
            out_valid   <= 1'b1;
            out_data    <= in_is_md ? '0 : alu_result;
            out_rd      <= in_rd;
            out_illegal <= in_is_md;
`endif
`ifdef EXEC_STAGE_MULDIV_EN
        end else if (state_reg == FINISH && slot_free) begin
            out_valid   <= 1'b1;
            out_data    <= md_result;
            out_rd      <= rd_reg;
            out_illegal <= 1'b0;
`endif
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_stage_md.sv
// Directed, table-driven bench for execute_stage_md. Mul/div vectors are
// exercised when EXEC_STAGE_MULDIV_EN is defined; otherwise the illegal path.

module tb_execute_stage_md;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_is_md = 1'b0;
    logic [2:0]      in_md_op = '0;
    logic            in_alu_enable = 1'b0;
    logic [3:0]      in_alu_sel = '0;
    logic [5:0]      in_shift_amt = '0;
    logic [XLEN-1:0] in_a = '0;
    logic [XLEN-1:0] in_b = '0;
    logic [4:0]      in_rd = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_data;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic            busy;

    int checks = 0;
    int errors = 0;

    execute_stage_md dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_md(in_is_md), .in_md_op(in_md_op), .in_alu_enable(in_alu_enable),
        .in_alu_sel(in_alu_sel), .in_shift_amt(in_shift_amt), .in_a(in_a),
        .in_b(in_b), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end else begin
            $display("ok   %s = %h", nm, act);
        end
    endfunction

    typedef struct {
        logic [3:0]  sel;
        logic        en;
        logic [5:0]  sh;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } md_vec_t;

    alu_vec_t alu_tab[12];
    md_vec_t  md_tab[13];

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        alu_tab[0]  = '{4'd0, 1'b1, 6'd0,  64'd3, 64'd4, 64'd7};
        alu_tab[1]  = '{4'd1, 1'b1, 6'd0,  64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
        alu_tab[2]  = '{4'd2, 1'b1, 6'd0,  64'hF0F0, 64'hFF00, 64'hF000};
        alu_tab[3]  = '{4'd3, 1'b1, 6'd0,  64'h0F, 64'hF0, 64'hFF};
        alu_tab[4]  = '{4'd4, 1'b1, 6'd0,  64'hFF, 64'h0F, 64'hF0};
        alu_tab[5]  = '{4'd5, 1'b1, 6'd63, 64'd1, 64'd0, 64'h8000_0000_0000_0000};
        alu_tab[6]  = '{4'd6, 1'b1, 6'd4,  64'h8000_0000_0000_0000, 64'd0, 64'h0800_0000_0000_0000};
        alu_tab[7]  = '{4'd7, 1'b1, 6'd4,  64'h8000_0000_0000_0000, 64'd0, 64'hF800_0000_0000_0000};
        alu_tab[8]  = '{4'd8, 1'b1, 6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
        alu_tab[9]  = '{4'd9, 1'b1, 6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
        alu_tab[10] = '{4'd0, 1'b0, 6'd0,  64'd3, 64'd4, 64'd0};
        alu_tab[11] = '{4'd0, 1'b1, 6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};

        md_tab[0]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
        md_tab[1]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        md_tab[2]  = '{3'b101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        md_tab[3]  = '{3'b111, 64'd5, 64'd0, 64'd5};
        md_tab[4]  = '{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        md_tab[5]  = '{3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        md_tab[6]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        md_tab[7]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        md_tab[8]  = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
        md_tab[9]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        md_tab[10] = '{3'b100, 64'd100, 64'd7, 64'd14};
        md_tab[11] = '{3'b110, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2};
        md_tab[12] = '{3'b000, 64'h1_2345_6789, 64'h1000, 64'h1234_5678_9000};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);

        // ALU vectors.
        for (int i = 0; i < 12; i++) begin
            check($sformatf("alu%0d_in_ready", i), 64'(in_ready), 64'd1);
            in_valid = 1'b1; in_is_md = 1'b0;
            in_alu_sel = alu_tab[i].sel; in_alu_enable = alu_tab[i].en;
            in_shift_amt = alu_tab[i].sh; in_a = alu_tab[i].a; in_b = alu_tab[i].b;
            in_rd = 5'(i + 1);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("alu%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("alu%0d_data", i), out_data, alu_tab[i].exp);
            check($sformatf("alu%0d_rd", i), 64'(out_rd), 64'(i + 1));
            check($sformatf("alu%0d_illegal", i), 64'(out_illegal), 64'd0);
            @(negedge clk);
        end
        check("alu_drained", 64'(out_valid), 64'd0);

        // ALU back-pressure: 3+4 held while stalled, then 5+6 enters on drain.
        out_ready = 1'b0;
        in_valid = 1'b1; in_is_md = 1'b0; in_alu_enable = 1'b1; in_alu_sel = 4'd0;
        in_a = 64'd3; in_b = 64'd4; in_rd = 5'd1;
        @(negedge clk);
        in_a = 64'd5; in_b = 64'd6; in_rd = 5'd2;
        check("bp_first_data", out_data, 64'd7);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("bp_hold_data", out_data, 64'd7);
            check("bp_hold_rd", 64'(out_rd), 64'd1);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check("bp_second_data", out_data, 64'd11);
        check("bp_second_rd", 64'(out_rd), 64'd2);
        @(negedge clk);
        check("bp_drained", 64'(out_valid), 64'd0);

`ifdef EXEC_STAGE_MULDIV_EN
        // Mul/div vectors with latency check.
        for (int i = 0; i < 13; i++) begin
            int n;
            in_valid = 1'b1; in_is_md = 1'b1; in_md_op = md_tab[i].op;
            in_a = md_tab[i].a; in_b = md_tab[i].b; in_rd = 5'(i + 3);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("md%0d_busy", i), 64'(busy), 64'd1);
            check($sformatf("md%0d_in_ready", i), 64'(in_ready), 64'd0);
            n = 1;
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("md%0d_latency", i), 64'(n - 1), 64'(XLEN + 1));
            check($sformatf("md%0d_data", i), out_data, md_tab[i].exp);
            check($sformatf("md%0d_rd", i), 64'(out_rd), 64'(i + 3));
            check($sformatf("md%0d_illegal", i), 64'(out_illegal), 64'd0);
            check($sformatf("md%0d_busy_done", i), 64'(busy), 64'd0);
            @(negedge clk);
        end

        // Reset 10 cycles into a DIV discards it.
        begin
            logic seen;
            in_valid = 1'b1; in_is_md = 1'b1; in_md_op = 3'b100;
            in_a = 64'd100; in_b = 64'd7; in_rd = 5'd9;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (9) @(negedge clk);
            rst = 1'b1;
            repeat (2) begin
                @(negedge clk);
                check("mid_rst_out_valid", 64'(out_valid), 64'd0);
                check("mid_rst_busy", 64'(busy), 64'd0);
            end
            rst = 1'b0;
            @(negedge clk);
            check("mid_rst_in_ready", 64'(in_ready), 64'd1);
            seen = 1'b0;
            repeat (80) begin
                @(negedge clk);
                if (out_valid || busy) seen = 1'b1;
            end
            check("mid_rst_no_result", 64'(seen), 64'd0);
        end
`else
        // Mul/div request without the unit: one-cycle illegal result.
        in_valid = 1'b1; in_is_md = 1'b1; in_md_op = 3'b000;
        in_a = 64'd3; in_b = 64'd4; in_rd = 5'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("ill_valid", 64'(out_valid), 64'd1);
        check("ill_data", out_data, 64'd0);
        check("ill_illegal", 64'(out_illegal), 64'd1);
        check("ill_rd", 64'(out_rd), 64'd7);
        check("ill_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("ill_drained", 64'(out_valid), 64'd0);
        check("ill_busy_after", 64'(busy), 64'd0);

        // A following ALU op clears the illegal flag.
        in_valid = 1'b1; in_is_md = 1'b0; in_alu_sel = 4'd0;
        in_a = 64'd10; in_b = 64'd20; in_rd = 5'd8;
        @(negedge clk);
        in_valid = 1'b0;
        check("post_ill_data", out_data, 64'd30);
        check("post_ill_illegal", 64'(out_illegal), 64'd0);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
